// File: rtl/streaming_dna_matcher.sv
// Streaming DNA template matcher. A window of tlen bases slides over the
// incoming 2-bit base stream. Each full window is compared base by base with
// the loaded template, and a hit is reported when the mismatch count is at or
// below the threshold. The pipeline is fixed: window register, stage 1 copy,
// stage 2 count/hit.

// Per-base compare lane: flags a differing 2-bit base inside the active length.
module dna_base_cmp (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       en,
  output logic       mism
);
  assign mism = en & (a != b);
endmodule

module streaming_dna_matcher #(
  parameter int MAX_LEN = 32,
  parameter int POS_W   = 16,
  parameter int CNT_W   = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_template,
  input  logic [2*MAX_LEN-1:0] template,
  input  logic [CNT_W-1:0]     tlen,
  input  logic [CNT_W-1:0]     threshold,
  input  logic                 start,
  input  logic                 base_valid,
  input  logic [1:0]           base_in,
  input  logic                 base_last,
  output logic                 busy,
  output logic                 hit_valid,
  output logic [POS_W-1:0]     hit_pos,
  output logic [CNT_W-1:0]     hit_mism,
  output logic [POS_W-1:0]     hit_count,
  output logic                 done
);
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                      state, state_nxt;
  logic                        done_nxt;
  logic [MAX_LEN-1:0][1:0]     tmpl_r, win, win_up, win_nxt, s1_win;
  logic [CNT_W-1:0]            tlen_r, thr_r, fill, fill_nxt, tlen_c;
  logic                        loaded;
  logic [POS_W-1:0]            pos, win_pos, s1_pos;
  // vld_pipe tracks every accepted base through the pipe (drain control);
  // full_pipe marks the entries that carry a complete window.
  logic [STAGES:0]             vld_pipe, full_pipe;
  logic [MAX_LEN-1:0]          lane_en, lane_mism;
  logic [CNT_W-1:0]            mism_cnt;
  logic                        accept, start_ok, load_ok, hit;

  assign accept   = (state == RUN) && base_valid;
  assign load_ok  = (state == IDLE) && load_template;
  // A load in the same cycle counts as loaded, so start can use it at once.
  assign start_ok = (state == IDLE) && start && (loaded || load_template);
  assign tlen_c   = (tlen == '0 || tlen > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : tlen;
  assign fill_nxt = (fill == tlen_r) ? fill : fill + 1'b1;
  assign busy     = (state != IDLE);
  assign win_up   = {2'b00, win[MAX_LEN-1:1]};

  // Next window: the newest base lands at slot tlen-1, older bases move down
  // so slot 0 always holds the oldest base (aligned with template base 0).
  always_comb begin
    win_nxt = win;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (CNT_W'(i + 1) == tlen_r)     win_nxt[i] = base_in;
      else if (CNT_W'(i + 1) < tlen_r) win_nxt[i] = win_up[i];
    end
  end

  // FSM next-state and done strobe.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = RUN;
      RUN:   if (accept && base_last) state_nxt = DRAIN;
      DRAIN: if (vld_pipe == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and done register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Template configuration, captured only while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmpl_r <= '0;
      tlen_r <= '0;
      thr_r  <= '0;
      loaded <= 1'b0;
    end else if (load_ok) begin
      tmpl_r <= template;
      tlen_r <= tlen_c;
      thr_r  <= threshold;
      loaded <= 1'b1;
    end
  end

  // Window, fill and position counters; first pipeline stage entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win          <= '0;
      fill         <= '0;
      pos          <= '0;
      win_pos      <= '0;
      vld_pipe[0]  <= 1'b0;
      full_pipe[0] <= 1'b0;
    end else begin
      vld_pipe[0]  <= accept;
      full_pipe[0] <= accept && (fill_nxt == tlen_r);
      if (start_ok) begin
        win  <= '0;
        fill <= '0;
        pos  <= '0;
      end else if (accept) begin
        win     <= win_nxt;
        fill    <= fill_nxt;
        pos     <= pos + 1'b1;
        win_pos <= pos - POS_W'(tlen_r) + 1'b1;
      end
    end
  end

  // Stage 1: snapshot of the window and its start position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_win       <= '0;
      s1_pos       <= '0;
      vld_pipe[1]  <= 1'b0;
      full_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1]  <= vld_pipe[0];
      full_pipe[1] <= full_pipe[0];
      if (full_pipe[0]) begin
        s1_win <= win;
        s1_pos <= win_pos;
      end
    end
  end

  // Per-base compare lanes; bases beyond tlen are masked off.
  for (genvar j = 0; j < MAX_LEN; j++) begin : g_lane
    assign lane_en[j] = (CNT_W'(j) < tlen_r);
    dna_base_cmp u_cmp (
      .a    (s1_win[j]),
      .b    (tmpl_r[j]),
      .en   (lane_en[j]),
      .mism (lane_mism[j])
    );
  end

  // Mismatch population count across lanes.
  always_comb begin
    mism_cnt = '0;
    for (int j = 0; j < MAX_LEN; j++) mism_cnt = mism_cnt + CNT_W'(lane_mism[j]);
  end

  assign hit = full_pipe[1] && (mism_cnt <= thr_r);

  // Stage 2: hit outputs; pos/mism hold between hits, count saturates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_valid <= 1'b0;
      hit_pos   <= '0;
      hit_mism  <= '0;
      hit_count <= '0;
    end else begin
      hit_valid <= hit;
      if (hit) begin
        hit_pos  <= s1_pos;
        hit_mism <= mism_cnt;
      end
      if (start_ok)                      hit_count <= '0;
      else if (hit && hit_count != '1)   hit_count <= hit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_streaming_dna_matcher.sv
// Directed bench for streaming_dna_matcher: hand-computed hit positions,
// mismatch counts, latencies and control behaviour.
module tb_streaming_dna_matcher;
  localparam int MAX_LEN = 32;
  localparam int POS_W   = 16;
  localparam int CNT_W   = 6;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 load_template;
  logic [2*MAX_LEN-1:0] template;
  logic [CNT_W-1:0]     tlen, threshold;
  logic                 start, base_valid, base_last;
  logic [1:0]           base_in;
  logic                 busy, hit_valid, done;
  logic [POS_W-1:0]     hit_pos, hit_count;
  logic [CNT_W-1:0]     hit_mism;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hpos[$], hmism[$], hcyc[$], acc[$];
  int done_cnt = 0;
  int done_cyc = 0;

  streaming_dna_matcher #(.MAX_LEN(MAX_LEN), .POS_W(POS_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .load_template(load_template), .template(template),
    .tlen(tlen), .threshold(threshold), .start(start), .base_valid(base_valid),
    .base_in(base_in), .base_last(base_last), .busy(busy), .hit_valid(hit_valid),
    .hit_pos(hit_pos), .hit_mism(hit_mism), .hit_count(hit_count), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record hits and done pulses away from the active edge.
  always @(negedge clock) begin
    if (hit_valid) begin
      hpos.push_back(int'(hit_pos));
      hmism.push_back(int'(hit_mism));
      hcyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [1:0] enc(input byte c);
    case (c)
      "A": return 2'b00;
      "C": return 2'b01;
      "G": return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [2*MAX_LEN-1:0] mk_tmpl(input string s, input logic [1:0] pad);
    logic [2*MAX_LEN-1:0] t;
    for (int i = 0; i < MAX_LEN; i++) t[2*i +: 2] = (i < s.len()) ? enc(s[i]) : pad;
    return t;
  endfunction

  task automatic clr();
    hpos.delete(); hmism.delete(); hcyc.delete(); acc.delete();
    done_cnt = 0;
  endtask

  task automatic ld(input string s, input int tl, input int thr, input bit with_start);
    template = mk_tmpl(s, 2'b00); tlen = CNT_W'(tl); threshold = CNT_W'(thr);
    load_template = 1'b1; start = with_start;
    @(posedge clock); #1;
    load_template = 1'b0; start = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Idle gap cycles drive base_last without base_valid, which must be ignored.
  task automatic send(input string s, input int gap, input bit last_at_end);
    for (int k = 0; k < s.len(); k++) begin
      base_valid = 1'b1; base_in = enc(s[k]);
      base_last  = last_at_end && (k == s.len() - 1);
      @(posedge clock); #1;
      acc.push_back(cyc);
      base_valid = 1'b0; base_last = 1'b0;
      for (int g = 0; g < gap; g++) begin
        base_last = 1'b1;
        @(posedge clock); #1;
        base_last = 1'b0;
      end
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && done_cnt == 0; k++) begin
      @(posedge clock); #3;
    end
    repeat (2) @(posedge clock);
    #3;
    chk("done_once", done_cnt, 1);
  endtask

  initial begin
    reset = 1'b1; load_template = 1'b0; template = '0; tlen = '0; threshold = '0;
    start = 1'b0; base_valid = 1'b0; base_in = 2'b00; base_last = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_hit_pos", hit_pos, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // start with nothing loaded is ignored
    go();
    chk("noload_busy", busy, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("noload_busy_later", busy, 0);

    // exact match
    clr();
    ld("ACGT", 4, 0, 0);
    go();
    chk("run_busy", busy, 1);
    send("TACGTA", 0, 1);
    wait_done();
    chk("exact_nhits", hpos.size(), 1);
    chk("exact_pos", qat(hpos, 0), 1);
    chk("exact_mism", qat(hmism, 0), 0);
    chk("exact_lat", qat(hcyc, 0) - qat(acc, 4), 2);
    chk("exact_done_lat", done_cyc - qat(acc, 5), 3);
    chk("exact_count", hit_count, 1);
    chk("exact_busy_after", busy, 0);

    // variation tolerance
    clr();
    ld("ACGT", 4, 1, 0);
    go();
    send("ACCT", 0, 1);
    wait_done();
    chk("var_nhits", hpos.size(), 1);
    chk("var_pos", qat(hpos, 0), 0);
    chk("var_mism", qat(hmism, 0), 1);
    clr();
    ld("ACGT", 4, 0, 0);
    go();
    send("ACCT", 0, 1);
    wait_done();
    chk("var0_nhits", hpos.size(), 0);

    // overlapping hits, upper template bases are T but masked by tlen=2
    clr();
    template = mk_tmpl("AA", 2'b11); tlen = 6'd2; threshold = 6'd0;
    load_template = 1'b1;
    @(posedge clock); #1;
    load_template = 1'b0;
    go();
    send("AAAA", 0, 1);
    wait_done();
    chk("ovl_nhits", hpos.size(), 3);
    chk("ovl_pos0", qat(hpos, 0), 0);
    chk("ovl_pos1", qat(hpos, 1), 1);
    chk("ovl_pos2", qat(hpos, 2), 2);
    chk("ovl_consec", qat(hcyc, 2) - qat(hcyc, 0), 2);
    chk("ovl_count", hit_count, 3);

    // gapped input
    clr();
    ld("ACGT", 4, 0, 0);
    go();
    send("TACGTA", 2, 1);
    wait_done();
    chk("gap_nhits", hpos.size(), 1);
    chk("gap_pos", qat(hpos, 0), 1);
    chk("gap_lat", qat(hcyc, 0) - qat(acc, 4), 2);

    // stream shorter than tlen
    clr();
    go();
    send("ACG", 0, 1);
    wait_done();
    chk("short_nhits", hpos.size(), 0);
    chk("short_count", hit_count, 0);

    // load during RUN is ignored
    clr();
    go();
    send("T", 0, 0);
    ld("GGGG", 4, 0, 0);
    send("ACGTA", 0, 1);
    wait_done();
    chk("runload_nhits", hpos.size(), 1);
    chk("runload_pos", qat(hpos, 0), 1);

    // start and load together: new template TACG wins
    clr();
    ld("TACG", 4, 0, 1);
    send("TACGTA", 0, 1);
    wait_done();
    chk("ldstart_nhits", hpos.size(), 1);
    chk("ldstart_pos", qat(hpos, 0), 0);

    // reset while a matching window is in flight
    clr();
    ld("ACGT", 4, 0, 0);
    go();
    send("TACGT", 0, 0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_hit_valid", hit_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_count", hit_count, 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    chk("mrst_nhits", hpos.size(), 0);
    chk("mrst_ndone", done_cnt, 0);
    chk("mrst_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
